// File: rtl/mcdf_pkt_arbiter_if.sv
// -----------------------------------------------------------------------------
// mcdf_pkt_arbiter_if
// Bundles the MCDF arbiter's channel, configuration and formatter signals.
//   slvN_en_i / slvN_prio_i / slvN_pkglen_i : per-channel config from registers
//   slvN_val_i / slvN_data_i                 : per-channel FIFO head word
//   slvN_ack_o                               : per-channel pop strobe
//   fmt_ready_i                              : formatter accepts a word
//   a2f_*                                    : packet stream towards formatter
//   arb_busy_o                               : a packet is in progress
// Modports:
//   master : the arbiter's view (drives acks, a2f_* and busy)
//   slave  : the environment's view (drives channels, config and ready)
// -----------------------------------------------------------------------------
interface mcdf_pkt_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int PRIO_W = 2,
    parameter int LEN_W  = 3
);
    logic              slv0_en_i;
    logic [PRIO_W-1:0] slv0_prio_i;
    logic [LEN_W-1:0]  slv0_pkglen_i;
    logic              slv0_val_i;
    logic [DATA_W-1:0] slv0_data_i;
    logic              slv0_ack_o;

    logic              slv1_en_i;
    logic [PRIO_W-1:0] slv1_prio_i;
    logic [LEN_W-1:0]  slv1_pkglen_i;
    logic              slv1_val_i;
    logic [DATA_W-1:0] slv1_data_i;
    logic              slv1_ack_o;

    logic              slv2_en_i;
    logic [PRIO_W-1:0] slv2_prio_i;
    logic [LEN_W-1:0]  slv2_pkglen_i;
    logic              slv2_val_i;
    logic [DATA_W-1:0] slv2_data_i;
    logic              slv2_ack_o;

    logic              fmt_ready_i;
    logic              a2f_val_o;
    logic [DATA_W-1:0] a2f_data_o;
    logic [1:0]        a2f_id_o;
    logic              a2f_sop_o;
    logic              a2f_eop_o;
    logic              arb_busy_o;

    modport master (
        input  slv0_en_i, slv0_prio_i, slv0_pkglen_i, slv0_val_i, slv0_data_i,
        input  slv1_en_i, slv1_prio_i, slv1_pkglen_i, slv1_val_i, slv1_data_i,
        input  slv2_en_i, slv2_prio_i, slv2_pkglen_i, slv2_val_i, slv2_data_i,
        input  fmt_ready_i,
        output slv0_ack_o, slv1_ack_o, slv2_ack_o,
        output a2f_val_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o, arb_busy_o
    );

    modport slave (
        output slv0_en_i, slv0_prio_i, slv0_pkglen_i, slv0_val_i, slv0_data_i,
        output slv1_en_i, slv1_prio_i, slv1_pkglen_i, slv1_val_i, slv1_data_i,
        output slv2_en_i, slv2_prio_i, slv2_pkglen_i, slv2_val_i, slv2_data_i,
        output fmt_ready_i,
        input  slv0_ack_o, slv1_ack_o, slv2_ack_o,
        input  a2f_val_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o, arb_busy_o
    );
endinterface

// File: rtl/mcdf_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// mcdf_pkt_arbiter
// Packet-level arbiter between the three MCDF slave channel FIFOs and the
// formatter. In IDLE it picks one eligible channel (enabled and non-empty):
// lowest priority value wins, ties resolved round-robin starting after the
// last granted channel. It then streams exactly one packet of the decoded
// length from that channel, inserts one GAP bubble, and re-arbitrates.
// Ports:
//   clk_i  : clock, all flops on posedge
//   rstn_i : asynchronous active-low reset
//   bus    : mcdf_pkt_arbiter_if.master (channels, config, formatter stream)
// -----------------------------------------------------------------------------
module mcdf_pkt_arbiter #(
    parameter int DATA_W = 32,
    parameter int PRIO_W = 2,
    parameter int LEN_W  = 3
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    mcdf_pkt_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Packet length code to word count; codes above 3 saturate at 32 words.
    function automatic logic [5:0] decode_len(input logic [LEN_W-1:0] code);
        logic [5:0] len;
        case (code)
            LEN_W'(0): len = 6'd4;
            LEN_W'(1): len = 6'd8;
            LEN_W'(2): len = 6'd16;
            default:   len = 6'd32;
        endcase
        return len;
    endfunction

    // Channel index successor, modulo 3.
    function automatic logic [1:0] next_id(input logic [1:0] id);
        logic [1:0] nxt;
        case (id)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [5:0]        cnt_r;
    logic [5:0]        len_r;
    logic [1:0]        cur_id_r;
    logic [1:0]        rr_ptr_r;

    logic [2:0]        en_s;
    logic [2:0]        val_s;
    logic [2:0]        elig_s;
    logic [PRIO_W-1:0] prio_s   [3];
    logic [LEN_W-1:0]  pkglen_s [3];
    logic [DATA_W-1:0] data_s   [3];

    logic              any_elig_s;
    logic [1:0]        win_id_s;
    logic [PRIO_W-1:0] best_prio_s;
    logic [1:0]        scan_id_s;
    logic              take_s;

    logic              cur_val_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              transfer_s;
    logic              last_word_s;

    logic              a2f_val_s;
    logic [DATA_W-1:0] a2f_data_s;
    logic              a2f_sop_s;
    logic              a2f_eop_s;
    logic [2:0]        ack_s;

    assign en_s  = {bus.slv2_en_i,  bus.slv1_en_i,  bus.slv0_en_i};
    assign val_s = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    assign elig_s = en_s & val_s;

    assign prio_s[0]   = bus.slv0_prio_i;
    assign prio_s[1]   = bus.slv1_prio_i;
    assign prio_s[2]   = bus.slv2_prio_i;
    assign pkglen_s[0] = bus.slv0_pkglen_i;
    assign pkglen_s[1] = bus.slv1_pkglen_i;
    assign pkglen_s[2] = bus.slv2_pkglen_i;
    assign data_s[0]   = bus.slv0_data_i;
    assign data_s[1]   = bus.slv1_data_i;
    assign data_s[2]   = bus.slv2_data_i;

    // Winner search: visit channels in round-robin order starting after
    // rr_ptr and keep only strictly better priorities, so among equal
    // priorities the first one met in round-robin order wins.
    always_comb begin
        scan_id_s   = next_id(rr_ptr_r);
        any_elig_s  = 1'b0;
        win_id_s    = 2'd0;
        best_prio_s = '0;
        take_s      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            take_s      = elig_s[scan_id_s] && (!any_elig_s || (prio_s[scan_id_s] < best_prio_s));
            win_id_s    = take_s ? scan_id_s : win_id_s;
            best_prio_s = take_s ? prio_s[scan_id_s] : best_prio_s;
            any_elig_s  = any_elig_s | take_s;
            scan_id_s   = next_id(scan_id_s);
        end
    end

    // Mux the granted channel's head word and valid.
    always_comb begin
        cur_val_s  = 1'b0;
        cur_data_s = '0;
        case (cur_id_r)
            2'd0: begin
                cur_val_s  = val_s[0];
                cur_data_s = data_s[0];
            end
            2'd1: begin
                cur_val_s  = val_s[1];
                cur_data_s = data_s[1];
            end
            2'd2: begin
                cur_val_s  = val_s[2];
                cur_data_s = data_s[2];
            end
            default: begin
                cur_val_s  = 1'b0;
                cur_data_s = '0;
            end
        endcase
    end

    assign transfer_s  = (state_r == ST_SEND) && cur_val_s && bus.fmt_ready_i;
    assign last_word_s = (cnt_r == (len_r - 6'd1));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_elig_s) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (transfer_s && last_word_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_GAP:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Packet context: grant latched in IDLE (config is only looked at here),
    // word counter advances only on an accepted transfer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r    <= 6'd0;
            len_r    <= 6'd4;
            cur_id_r <= 2'd0;
            rr_ptr_r <= 2'd2;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_elig_s) begin
                        cur_id_r <= win_id_s;
                        rr_ptr_r <= win_id_s;
                        len_r    <= decode_len(pkglen_s[win_id_s]);
                        cnt_r    <= 6'd0;
                    end
                end
                ST_SEND: begin
                    if (transfer_s) begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Formatter-side outputs and pop strobes; everything is quiet outside SEND.
    always_comb begin
        a2f_val_s  = 1'b0;
        a2f_data_s = '0;
        a2f_sop_s  = 1'b0;
        a2f_eop_s  = 1'b0;
        ack_s      = 3'b000;
        if (state_r == ST_SEND) begin
            a2f_val_s        = cur_val_s;
            a2f_data_s       = cur_data_s;
            a2f_sop_s        = (cnt_r == 6'd0);
            a2f_eop_s        = last_word_s;
            ack_s[cur_id_r]  = transfer_s;
        end else begin
            a2f_val_s  = 1'b0;
            a2f_data_s = '0;
        end
    end

    assign bus.a2f_val_o  = a2f_val_s;
    assign bus.a2f_data_o = a2f_data_s;
    assign bus.a2f_sop_o  = a2f_sop_s;
    assign bus.a2f_eop_o  = a2f_eop_s;
    assign bus.a2f_id_o   = cur_id_r;
    assign bus.arb_busy_o = (state_r != ST_IDLE);
    assign bus.slv0_ack_o = ack_s[0];
    assign bus.slv1_ack_o = ack_s[1];
    assign bus.slv2_ack_o = ack_s[2];

endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mcdf_pkt_arbiter
// Randomised bench for mcdf_pkt_arbiter. Each channel FIFO is a push/pop
// counter pair whose head word encodes {channel, sequence}. A packet-level
// reference model decides grants from the priority/round-robin rules and
// tracks word counts, gaps and the per-channel sequence expected next.
// -----------------------------------------------------------------------------
module tb_mcdf_pkt_arbiter;

    localparam int DATA_W = 32;
    localparam int PRIO_W = 2;
    localparam int LEN_W  = 3;
    localparam int N_CYC  = 3000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mcdf_pkt_arbiter_if #(.DATA_W(DATA_W), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) bus ();

    mcdf_pkt_arbiter #(.DATA_W(DATA_W), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    logic [2:0]        en_d;
    logic [2:0]        val_d;
    logic [PRIO_W-1:0] prio_d [3];
    logic [LEN_W-1:0]  code_d [3];
    logic [DATA_W-1:0] data_d [3];
    logic              ready_d;

    assign bus.slv0_en_i     = en_d[0];
    assign bus.slv1_en_i     = en_d[1];
    assign bus.slv2_en_i     = en_d[2];
    assign bus.slv0_val_i    = val_d[0];
    assign bus.slv1_val_i    = val_d[1];
    assign bus.slv2_val_i    = val_d[2];
    assign bus.slv0_prio_i   = prio_d[0];
    assign bus.slv1_prio_i   = prio_d[1];
    assign bus.slv2_prio_i   = prio_d[2];
    assign bus.slv0_pkglen_i = code_d[0];
    assign bus.slv1_pkglen_i = code_d[1];
    assign bus.slv2_pkglen_i = code_d[2];
    assign bus.slv0_data_i   = data_d[0];
    assign bus.slv1_data_i   = data_d[1];
    assign bus.slv2_data_i   = data_d[2];
    assign bus.fmt_ready_i   = ready_d;

    wire [2:0] ack_obs = {bus.slv2_ack_o, bus.slv1_ack_o, bus.slv0_ack_o};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Word count for a length code.
    function automatic int len_of(input int code);
        if (code == 0) return 4;
        if (code == 1) return 8;
        if (code == 2) return 16;
        return 32;
    endfunction

    // Grant rule: best priority level first, then channels in order after last.
    function automatic int pick(input logic [2:0] elig, input int pr0, input int pr1,
                                input int pr2, input int last);
        int pr [3];
        pr[0] = pr0; pr[1] = pr1; pr[2] = pr2;
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (last + k) % 3;
                if (elig[c] && pr[c] == p) return c;
            end
        end
        return -1;
    endfunction

    // Source FIFOs
    int push_cnt [3];
    int pop_cnt  [3];
    logic [2:0] ack_seen;
    logic [2:0] src_stall;

    // Reference model
    int mode;       // 0 = waiting to arbitrate, 1 = in packet, 2 = gap bubble
    int exp_id;
    int exp_len;
    int sent;
    int last_grant;
    int exp_seq [3];
    int grants;
    bit reset_done;

    task automatic zero_outputs_check(input string pfx);
        check({pfx, "_val"},  32'(bus.a2f_val_o),  32'd0);
        check({pfx, "_sop"},  32'(bus.a2f_sop_o),  32'd0);
        check({pfx, "_eop"},  32'(bus.a2f_eop_o),  32'd0);
        check({pfx, "_busy"}, 32'(bus.arb_busy_o), 32'd0);
        check({pfx, "_ack"},  32'(ack_obs),        32'd0);
        check({pfx, "_data"}, bus.a2f_data_o,      32'd0);
    endtask

    initial begin
        int w;
        int cyc;
        en_d    = 3'b000;
        val_d   = 3'b000;
        ready_d = 1'b0;
        for (int n = 0; n < 3; n++) begin
            prio_d[n]   = '0;
            code_d[n]   = '0;
            data_d[n]   = '0;
            push_cnt[n] = 0;
            pop_cnt[n]  = 0;
            exp_seq[n]  = 0;
        end
        ack_seen   = 3'b000;
        src_stall  = 3'b000;
        mode       = 0;
        exp_id     = 0;
        exp_len    = 4;
        sent       = 0;
        last_grant = 2;
        grants     = 0;
        reset_done = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        zero_outputs_check("reset");
        check("reset_id", 32'(bus.a2f_id_o), 32'd0);

        for (cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            rstn = 1'b1;
            ready_d = ($urandom_range(0, 4) != 0);
            for (int n = 0; n < 3; n++) begin
                if (ack_seen[n]) pop_cnt[n]++;
                if ($urandom_range(0, 1) == 0 && (push_cnt[n] - pop_cnt[n]) < 48) push_cnt[n]++;
                src_stall[n] = ($urandom_range(0, 9) == 0);
                // Configuration changes, shaped by phase
                if (cyc < 800 || cyc >= 2000) begin
                    if ($urandom_range(0, 19) == 0) begin
                        en_d[n]   = ($urandom_range(0, 3) != 0);
                        prio_d[n] = PRIO_W'($urandom_range(0, 3));
                        code_d[n] = LEN_W'($urandom_range(0, 7));
                    end
                end else if (cyc < 1400) begin
                    en_d[n]   = 1'b1;
                    prio_d[n] = PRIO_W'(1);
                    if ($urandom_range(0, 29) == 0) code_d[n] = LEN_W'($urandom_range(0, 1));
                end else begin
                    en_d[n]   = 1'b1;
                    code_d[n] = LEN_W'(3);
                    if ($urandom_range(0, 29) == 0) prio_d[n] = PRIO_W'($urandom_range(0, 3));
                end
                val_d[n]  = (push_cnt[n] != pop_cnt[n]) && !src_stall[n];
                data_d[n] = (push_cnt[n] != pop_cnt[n]) ? {8'(n), 24'(pop_cnt[n])} : '0;
            end

            @(negedge clk);
            case (mode)
                0: begin
                    zero_outputs_check("idle");
                    w = pick(en_d & val_d, int'(prio_d[0]), int'(prio_d[1]),
                             int'(prio_d[2]), last_grant);
                    if (w >= 0) begin
                        exp_id     = w;
                        last_grant = w;
                        exp_len    = len_of(int'(code_d[w]));
                        sent       = 0;
                        mode       = 1;
                        grants++;
                    end
                end
                1: begin
                    check("send_busy", 32'(bus.arb_busy_o), 32'd1);
                    check("send_id",   32'(bus.a2f_id_o),   32'(exp_id));
                    check("send_sop",  32'(bus.a2f_sop_o),  32'(sent == 0));
                    check("send_eop",  32'(bus.a2f_eop_o),  32'(sent == exp_len - 1));
                    check("send_val",  32'(bus.a2f_val_o),  32'(val_d[exp_id]));
                    check("send_data", bus.a2f_data_o,      data_d[exp_id]);
                    check("send_ack",  32'(ack_obs),
                          32'((val_d[exp_id] && ready_d) ? (1 << exp_id) : 0));
                    if (val_d[exp_id] && ready_d) begin
                        check("word_seq", bus.a2f_data_o, {8'(exp_id), 24'(exp_seq[exp_id])});
                        exp_seq[exp_id]++;
                        sent++;
                        if (sent == exp_len) mode = 2;
                    end
                end
                default: begin
                    check("gap_busy", 32'(bus.arb_busy_o), 32'd1);
                    check("gap_val",  32'(bus.a2f_val_o),  32'd0);
                    check("gap_ack",  32'(ack_obs),        32'd0);
                    check("gap_sop",  32'(bus.a2f_sop_o),  32'd0);
                    check("gap_eop",  32'(bus.a2f_eop_o),  32'd0);
                    mode = 0;
                end
            endcase
            ack_seen = ack_obs;

            // One asynchronous reset in the middle of a long packet
            if (!reset_done && cyc >= 1400 && mode == 1 && sent == 10) begin
                #2;
                rstn = 1'b0;
                #1;
                zero_outputs_check("midrst");
                check("midrst_id", 32'(bus.a2f_id_o), 32'd0);
                reset_done = 1'b1;
                ack_seen   = 3'b000;
                mode       = 0;
                last_grant = 2;
                for (int n = 0; n < 3; n++) exp_seq[n] = pop_cnt[n];
            end
        end

        check("mid_reset_seen", 32'(reset_done), 32'd1);
        check("grants_seen", 32'(grants > 20), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
